// File: rtl/bip_pkg.sv
// Shared definitions for the BIP run/step sequencer: opcode and command
// encodings, the run-controller state type and the halt-detect helper.
package bip_pkg;

   localparam logic [4:0] OP_HALT   = 5'b00000;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_REPORT = 3'd3,
      ST_CLEAR  = 3'd4
   } run_state_e;

   // HALT only counts away from PC 0: opcode 0 at reset PC is a normal word.
   function automatic logic is_halt(input logic [4:0] op, input logic pc_nonzero);
      return (op == OP_HALT) && pc_nonzero;
   endfunction

endpackage

// File: rtl/bip_run_ctrl_if.sv
// Host-side command/report handshake of the BIP run controller.
// master = debug host, slave = bip_run_ctrl.
interface bip_run_ctrl_if #(
   parameter int PC_WIDTH  = 11,
   parameter int CNT_WIDTH = 16
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd;
   logic                 rpt_valid;
   logic                 rpt_ready;
   logic [PC_WIDTH-1:0]  rpt_pc;
   logic [CNT_WIDTH-1:0] rpt_cycles;
   logic                 rpt_halted;
   logic                 rpt_timeout;

   modport master (
      output cmd_valid, cmd, rpt_ready,
      input  cmd_ready, rpt_valid, rpt_pc, rpt_cycles, rpt_halted, rpt_timeout
   );

   modport slave (
      input  cmd_valid, cmd, rpt_ready,
      output cmd_ready, rpt_valid, rpt_pc, rpt_cycles, rpt_halted, rpt_timeout
   );
endinterface

// File: rtl/bip_cycle_counter.sv
// Saturating executed-cycle counter with enable and synchronous clear.
module bip_cycle_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear wins, otherwise increment and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/bip_run_ctrl.sv
// Run/step sequencer for the BIP core: gates the core enable, detects HALT,
// counts enabled cycles and returns a result record to the debug host.
// Optional build macro BIP_CYCLE_LIMIT_EN bounds a RUN to MAX_CYCLES enabled
// cycles since the last CLEAR; without it runs are unbounded and
// rpt_timeout stays 0.
module bip_run_ctrl
   import bip_pkg::*;
#(
   parameter int PC_WIDTH   = 11,
   parameter int CNT_WIDTH  = 16,
   parameter int MAX_CYCLES = 2047
) (
   input  logic                clk,
   input  logic                reset,
   bip_run_ctrl_if.slave       host,
   input  logic [4:0]          opcode,
   input  logic [PC_WIDTH-1:0] pc,
   output logic                bip_enable,
   output logic                bip_reset,
   output logic                busy
);
   run_state_e           state_q, state_d;
   logic                 halted_q, halted_d;
   logic                 timeout_q, timeout_d;
   logic                 run_en_s;
   logic                 halt_now_s;
   logic                 limit_hit_s;
   logic                 cmd_fire_s;
   logic                 in_report_s;
   logic [CNT_WIDTH-1:0] cnt_s;

   assign halt_now_s = is_halt(opcode, pc != '0);
   assign cmd_fire_s = host.cmd_valid && (state_q == ST_IDLE);

`ifdef BIP_CYCLE_LIMIT_EN
   assign limit_hit_s = (cnt_s >= CNT_WIDTH'(MAX_CYCLES));
`else
   assign limit_hit_s = 1'b0;
`endif

   // Sequencer next state, sticky flags and core enable.
   always_comb begin
      state_d   = state_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      run_en_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire_s) begin
               case (host.cmd)
                  CMD_RUN:   state_d = halted_q ? ST_REPORT : ST_RUN;
                  CMD_STEP:  state_d = halted_q ? ST_REPORT : ST_STEP;
                  CMD_CLEAR: state_d = ST_CLEAR;
                  default:   state_d = ST_IDLE;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // HALT is never executed, so the PC freezes on the HALT word.
            if (halt_now_s) begin
               halted_d = 1'b1;
               state_d  = ST_REPORT;
            end else if (limit_hit_s) begin
               timeout_d = 1'b1;
               state_d   = ST_REPORT;
            end else begin
               run_en_s = 1'b1;
            end
         end
         ST_STEP: begin
            if (halt_now_s) begin
               halted_d = 1'b1;
            end else begin
               run_en_s = 1'b1;
            end
            state_d = ST_REPORT;
         end
         ST_REPORT: begin
            if (host.rpt_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REPORT;
            end
         end
         ST_CLEAR: begin
            halted_d  = 1'b0;
            timeout_d = 1'b0;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
      end
   end

   bip_cycle_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_cycle_counter (
      .clk   (clk),
      .reset (reset),
      .clr_i (state_q == ST_CLEAR),
      .en_i  (bip_enable),
      .cnt_o (cnt_s)
   );

   assign in_report_s = (state_q == ST_REPORT);

   // Enable is masked by reset so an aborted run stops in the reset cycle too.
   assign bip_enable = run_en_s && !reset;
   assign bip_reset  = reset || (state_q == ST_CLEAR);
   assign busy       = (state_q == ST_RUN) || (state_q == ST_STEP);

   assign host.cmd_ready = (state_q == ST_IDLE);
   assign host.rpt_valid = in_report_s;

   // Counter and flags settle on the REPORT entry edge and are frozen for
   // the whole REPORT state (no enable, no clear), so they form the held
   // payload. The core PC is likewise frozen while REPORT holds the enable
   // low, and reading it here includes the effect of the final enabled cycle.
   assign host.rpt_pc      = in_report_s ? pc : '0;
   assign host.rpt_cycles  = in_report_s ? cnt_s : '0;
   assign host.rpt_halted  = in_report_s && halted_q;
`ifdef BIP_CYCLE_LIMIT_EN
   assign host.rpt_timeout = in_report_s && timeout_q;
`else
   assign host.rpt_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bip_run_ctrl.sv
// Self-checking bench for bip_run_ctrl: directed command table, hand-written
// reset/back-pressure sequences and a randomized phase against a reference model.
module tb_bip_run_ctrl;
   import bip_pkg::*;

   localparam int PCW = 11;
   localparam int CW  = 16;
`ifdef BIP_CYCLE_LIMIT_EN
   localparam int MAXC   = 8;
   localparam bit LIM_EN = 1'b1;
`else
   localparam int MAXC   = 2047;
   localparam bit LIM_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [4:0]     opcode;
   logic [PCW-1:0] pc;
   logic           bip_enable, bip_reset, busy;
   logic [4:0]     prog [0:2047];

   bip_run_ctrl_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) host ();

   bip_run_ctrl #(.PC_WIDTH(PCW), .CNT_WIDTH(CW), .MAX_CYCLES(MAXC)) dut (
      .clk        (clk),
      .reset      (reset),
      .host       (host),
      .opcode     (opcode),
      .pc         (pc),
      .bip_enable (bip_enable),
      .bip_reset  (bip_reset),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Stand-in BIP core: straight-line program counter over a program memory.
   always @(posedge clk) begin
      if (bip_reset) pc <= '0;
      else if (bip_enable) pc <= pc + 11'd1;
   end
   assign opcode = prog[pc];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one command, follow it to its report (or back to IDLE), hold the
   // report for 'hold' cycles under back-pressure, then complete the transfer.
   task automatic run_cmd(input logic [1:0] c, input int hold,
                          output int en, output int rst_pulses, output bit got,
                          output int r_pc, output int r_cyc, output bit r_halt,
                          output bit r_tout);
      int  n;
      bit  done;
      en = 0; rst_pulses = 0; got = 1'b0; done = 1'b0;
      r_pc = 0; r_cyc = 0; r_halt = 1'b0; r_tout = 1'b0;
      @(negedge clk);
      n = 0;
      while (host.cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      host.cmd_valid = 1'b1;
      host.cmd       = c;
      @(posedge clk);
      #1;
      host.cmd_valid = 1'b0;
      host.cmd       = CMD_NOP;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (bip_enable === 1'b1) en++;
         if (bip_reset === 1'b1) rst_pulses++;
         if (host.rpt_valid === 1'b1) begin
            got = 1'b1; done = 1'b1; break;
         end
         if (host.cmd_ready === 1'b1) begin
            done = 1'b1; break;
         end
      end
      if (!done) chk("cmd_bound", 32'd0, 32'd1);
      if (got) begin
         r_pc   = int'(host.rpt_pc);
         r_cyc  = int'(host.rpt_cycles);
         r_halt = host.rpt_halted;
         r_tout = host.rpt_timeout;
         for (int i = 0; i < hold; i++) begin
            host.cmd_valid = 1'b1;
            host.cmd       = CMD_RUN;
            @(negedge clk);
            chk("hold_valid", {31'd0, host.rpt_valid}, 32'd1);
            chk("hold_cmd_ready", {31'd0, host.cmd_ready}, 32'd0);
            chk("hold_enable", {31'd0, bip_enable}, 32'd0);
            chk("hold_pc", {21'd0, host.rpt_pc}, r_pc);
            chk("hold_cycles", {16'd0, host.rpt_cycles}, r_cyc);
            chk("hold_halted", {31'd0, host.rpt_halted}, {31'd0, r_halt});
         end
         host.cmd_valid = 1'b0;
         host.cmd       = CMD_NOP;
         host.rpt_ready = 1'b1;
         @(posedge clk);
         #1;
         host.rpt_ready = 1'b0;
         @(negedge clk);
         chk("post_xfer_valid", {31'd0, host.rpt_valid}, 32'd0);
         chk("post_xfer_ready", {31'd0, host.cmd_ready}, 32'd1);
      end
   endtask

   // Reference model of the sequencer as seen by the host.
   int m_pc, m_cyc;
   bit m_halt, m_tout;

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_cmd(input logic [1:0] c, output int exp_en, output bit exp_rpt);
      exp_en = 0;
      exp_rpt = 1'b0;
      if (c == CMD_RUN) begin
         exp_rpt = 1'b1;
         if (!m_halt) begin
            for (int k = 0; k < 5000; k++) begin
               if (prog[m_pc] == OP_HALT && m_pc != 0) begin m_halt = 1'b1; break; end
               if (LIM_EN && m_cyc >= MAXC) begin m_tout = 1'b1; break; end
               m_pc  = (m_pc + 1) % 2048;
               m_cyc = sat(m_cyc + 1);
               exp_en++;
            end
         end
      end else if (c == CMD_STEP) begin
         exp_rpt = 1'b1;
         if (!m_halt) begin
            if (prog[m_pc] == OP_HALT && m_pc != 0) m_halt = 1'b1;
            else begin
               m_pc  = (m_pc + 1) % 2048;
               m_cyc = sat(m_cyc + 1);
               exp_en = 1;
            end
         end
      end else if (c == CMD_CLEAR) begin
         m_pc = 0; m_cyc = 0; m_halt = 1'b0; m_tout = 1'b0;
      end
   endtask

   typedef struct {
      logic [1:0] cmd;
      int         en;
      bit         rpt;
      int         pc;
      int         cyc;
      bit         halt;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int en, rp, r_pc, r_cyc, n, e_en, hold, sel;
      bit got, r_halt, r_tout, e_rpt, seen;
      logic [1:0] c;

      reset = 1'b1;
      host.cmd_valid = 1'b0;
      host.cmd       = CMD_NOP;
      host.rpt_ready = 1'b0;
      for (int i = 0; i < 2048; i++) prog[i] = 5'd1;
      prog[0] = OP_HALT;
      prog[5] = OP_HALT;

      tbl[0] = '{CMD_RUN,   5, 1'b1, 5, 5, 1'b1};
      tbl[1] = '{CMD_RUN,   0, 1'b1, 5, 5, 1'b1};
      tbl[2] = '{CMD_STEP,  0, 1'b1, 5, 5, 1'b1};
      tbl[3] = '{CMD_CLEAR, 0, 1'b0, 0, 0, 1'b0};
      tbl[4] = '{CMD_STEP,  1, 1'b1, 1, 1, 1'b0};
      tbl[5] = '{CMD_STEP,  1, 1'b1, 2, 2, 1'b0};
      tbl[6] = '{CMD_STEP,  1, 1'b1, 3, 3, 1'b0};
      tbl[7] = '{CMD_RUN,   2, 1'b1, 5, 5, 1'b1};
      tbl[8] = '{CMD_CLEAR, 0, 1'b0, 0, 0, 1'b0};
      tbl[9] = '{CMD_NOP,   0, 1'b0, 0, 0, 1'b0};

      // Reset state while reset is held.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, host.cmd_ready}, 32'd1);
      chk("rst_bip_reset", {31'd0, bip_reset}, 32'd1);
      chk("rst_enable", {31'd0, bip_enable}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rpt_valid", {31'd0, host.rpt_valid}, 32'd0);
      chk("rst_rpt_pc", {21'd0, host.rpt_pc}, 32'd0);
      chk("rst_rpt_cycles", {16'd0, host.rpt_cycles}, 32'd0);
      chk("rst_rpt_flags", {30'd0, host.rpt_halted, host.rpt_timeout}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release_bip_reset", {31'd0, bip_reset}, 32'd0);

      // Directed command table; the first report is held 10 cycles.
      for (int i = 0; i < 10; i++) begin
         hold = (i == 0) ? 10 : (i % 3);
         run_cmd(tbl[i].cmd, hold, en, rp, got, r_pc, r_cyc, r_halt, r_tout);
         chk($sformatf("tbl%0d_enables", i), en, tbl[i].en);
         chk($sformatf("tbl%0d_report", i), {31'd0, got}, {31'd0, tbl[i].rpt});
         if (tbl[i].rpt) begin
            chk($sformatf("tbl%0d_pc", i), r_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_cycles", i), r_cyc, tbl[i].cyc);
            chk($sformatf("tbl%0d_halted", i), {31'd0, r_halt}, {31'd0, tbl[i].halt});
            chk($sformatf("tbl%0d_timeout", i), {31'd0, r_tout}, 32'd0);
         end
         chk($sformatf("tbl%0d_bip_reset_pulses", i), rp, (tbl[i].cmd == CMD_CLEAR) ? 1 : 0);
         if (tbl[i].cmd == CMD_CLEAR) chk($sformatf("tbl%0d_pc_zero", i), {21'd0, pc}, 32'd0);
      end

      // Reset in the middle of a RUN aborts it with no report.
      prog[5] = 5'd1;
      @(negedge clk);
      host.cmd_valid = 1'b1;
      host.cmd       = CMD_RUN;
      @(posedge clk);
      #1;
      host.cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrun_enable_before", {31'd0, bip_enable}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrun_enable_after", {31'd0, bip_enable}, 32'd0);
      chk("midrun_busy_after", {31'd0, busy}, 32'd0);
      chk("midrun_cmd_ready", {31'd0, host.cmd_ready}, 32'd1);
      reset = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (host.rpt_valid === 1'b1) seen = 1'b1;
      end
      chk("midrun_no_report", {31'd0, seen}, 32'd0);
      chk("midrun_pc_zero", {21'd0, pc}, 32'd0);

      // Reset while a report is pending discards it and clears counter/flags.
      prog[5] = OP_HALT;
      @(negedge clk);
      host.cmd_valid = 1'b1;
      host.cmd       = CMD_RUN;
      @(posedge clk);
      #1;
      host.cmd_valid = 1'b0;
      n = 0;
      while (host.rpt_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midrpt_reached", {31'd0, host.rpt_valid}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrpt_discarded", {31'd0, host.rpt_valid}, 32'd0);
      run_cmd(CMD_STEP, 0, en, rp, got, r_pc, r_cyc, r_halt, r_tout);
      chk("midrpt_step_pc", r_pc, 1);
      chk("midrpt_step_cycles", r_cyc, 1);
      chk("midrpt_step_halted", {31'd0, r_halt}, 32'd0);

`ifdef BIP_CYCLE_LIMIT_EN
      // Infinite loop is cut after exactly MAXC enabled cycles.
      run_cmd(CMD_CLEAR, 0, en, rp, got, r_pc, r_cyc, r_halt, r_tout);
      for (int i = 1; i < 2048; i++) prog[i] = 5'd3;
      run_cmd(CMD_RUN, 2, en, rp, got, r_pc, r_cyc, r_halt, r_tout);
      chk("limit_enables", en, MAXC);
      chk("limit_cycles", r_cyc, MAXC);
      chk("limit_timeout", {31'd0, r_tout}, 32'd1);
      chk("limit_halted", {31'd0, r_halt}, 32'd0);
`endif

      // Randomized commands against the reference model.
      for (int i = 0; i < 2048; i++)
         prog[i] = ($urandom_range(0, 19) == 0) ? OP_HALT : 5'($urandom_range(1, 31));
      prog[2047] = OP_HALT;
      run_cmd(CMD_CLEAR, 0, en, rp, got, r_pc, r_cyc, r_halt, r_tout);
      m_pc = 0; m_cyc = 0; m_halt = 1'b0; m_tout = 1'b0;
      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 99);
         c = (sel < 30) ? CMD_RUN : (sel < 65) ? CMD_STEP : (sel < 80) ? CMD_CLEAR : CMD_NOP;
         hold = $urandom_range(0, 3);
         model_cmd(c, e_en, e_rpt);
         run_cmd(c, hold, en, rp, got, r_pc, r_cyc, r_halt, r_tout);
         chk($sformatf("rnd%0d_enables", i), en, e_en);
         chk($sformatf("rnd%0d_report", i), {31'd0, got}, {31'd0, e_rpt});
         if (e_rpt) begin
            chk($sformatf("rnd%0d_pc", i), r_pc, m_pc);
            chk($sformatf("rnd%0d_cycles", i), r_cyc, m_cyc);
            chk($sformatf("rnd%0d_halted", i), {31'd0, r_halt}, {31'd0, m_halt});
            chk($sformatf("rnd%0d_timeout", i), {31'd0, r_tout}, {31'd0, m_tout});
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
